// File: rtl/fc_pkg.sv
// Shared state encoding, default sizing and run-length formula for fc_layer_ctrl.
// Build option FC_LAYER_CTRL_RELU_EN (consumed by the top) clamps final sums at zero.
package fc_pkg;

    localparam int unsigned DEF_ADDR_WIDTH   = 10;
    localparam int unsigned DEF_PE_OUT_WIDTH = 24;
    localparam int unsigned DEF_LANES        = 2;
    localparam int unsigned DEF_IN_WORDS     = 6;
    localparam int unsigned DEF_OUT_CH       = 10;
    localparam int unsigned DEF_GEMM_LAT     = 18;

    typedef enum logic [3:0] {
        StIdle,
        StClear,
        StIssue,
        StWaitGemm,
        StAccRd,
        StAccWait,
        StAccWr,
        StMaxRd,
        StMaxWait,
        StMaxCmp,
        StFinish
    } fc_state_e;

    // Cycles from the cycle start is high through the done cycle, both inclusive:
    // 1 (start) + words (CLEAR) + words*in_words*(ISSUE + gemm_lat WAIT + RD/WAIT/WR)
    // + 3*words (MAX_RD/MAX_WAIT/MAX_CMP) + 1 (FINISH).
    function automatic int unsigned fc_run_cycles(input int unsigned out_ch,
                                                  input int unsigned lanes,
                                                  input int unsigned in_words,
                                                  input int unsigned gemm_lat);
        int unsigned words;
        words = out_ch / lanes;
        return words * in_words * (gemm_lat + 4) + words * 4 + 2;
    endfunction

endpackage

// File: rtl/fc_argmax.sv
// Running signed maximum over accumulator words, lanes scanned in ascending channel order.
// Ties keep the lower channel; the first lane of word 0 seeds the maximum.
module fc_argmax
    import fc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned PE_OUT_WIDTH = DEF_PE_OUT_WIDTH,
    parameter int unsigned LANES        = DEF_LANES,
    parameter int unsigned OUT_CH       = DEF_OUT_CH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cmp_i,
    input  logic                            first_i,
    input  logic [ADDR_WIDTH-1:0]           word_i,
    input  logic [LANES*PE_OUT_WIDTH-1:0]   data_i,
    output logic [$clog2(OUT_CH)-1:0]       nxt_idx_o,
    output logic [PE_OUT_WIDTH-1:0]         nxt_val_o
);

    localparam int unsigned IdxW = $clog2(OUT_CH);

    logic [IdxW-1:0]                max_idx_q;
    logic signed [PE_OUT_WIDTH-1:0] max_val_q;
    logic [IdxW-1:0]                best_idx;
    logic signed [PE_OUT_WIDTH-1:0] best_val;
    logic signed [PE_OUT_WIDTH-1:0] lane_val;

    always_comb begin
        best_idx = max_idx_q;
        best_val = max_val_q;
        lane_val = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_val = data_i[k*PE_OUT_WIDTH +: PE_OUT_WIDTH];
            // Strict greater-than keeps the earlier channel on a tie.
            if ((first_i && k == 0) || (lane_val > best_val)) begin
                best_val = lane_val;
                best_idx = IdxW'(32'(word_i) * LANES + 32'(k));
            end
        end
    end

    assign nxt_idx_o = best_idx;
    assign nxt_val_o = best_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_idx_q <= '0;
            max_val_q <= '0;
        end else if (cmp_i) begin
            max_idx_q <= best_idx;
            max_val_q <= best_val;
        end
    end

endmodule

// File: rtl/fc_layer_ctrl.sv
// Fully-connected layer sequencer: accumulates GEMM partial sums per channel, then argmax.
// Build option FC_LAYER_CTRL_RELU_EN clamps the sum written on the last input word at zero.
module fc_layer_ctrl
    import fc_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int unsigned PE_OUT_WIDTH = DEF_PE_OUT_WIDTH,
    parameter int unsigned LANES        = DEF_LANES,
    parameter int unsigned IN_WORDS     = DEF_IN_WORDS,
    parameter int unsigned OUT_CH       = DEF_OUT_CH,
    parameter int unsigned GEMM_LAT     = DEF_GEMM_LAT
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic [$clog2(OUT_CH)-1:0]       result_idx,
    output logic [PE_OUT_WIDTH-1:0]         result_val,
    output logic                            inp_en,
    output logic [ADDR_WIDTH-1:0]           inp_addr,
    output logic                            wgt_en,
    output logic [LANES*ADDR_WIDTH-1:0]     wgt_addr,
    input  logic [LANES*PE_OUT_WIDTH-1:0]   gemm_result,
    output logic                            acc_en,
    output logic                            acc_we,
    output logic [ADDR_WIDTH-1:0]           acc_addr,
    output logic [LANES*PE_OUT_WIDTH-1:0]   acc_wdata,
    input  logic [LANES*PE_OUT_WIDTH-1:0]   acc_rdata
);

    localparam int unsigned NumWords = OUT_CH / LANES;
    localparam int unsigned IdxW     = $clog2(OUT_CH);
    localparam int unsigned DataW    = LANES * PE_OUT_WIDTH;
    localparam int unsigned WaitW    = (GEMM_LAT > 1) ? $clog2(GEMM_LAT) : 1;

    localparam logic [ADDR_WIDTH-1:0] LastWord = ADDR_WIDTH'(NumWords - 1);
    localparam logic [ADDR_WIDTH-1:0] LastN    = ADDR_WIDTH'(IN_WORDS - 1);
    localparam logic [WaitW-1:0]      LastWait = WaitW'(GEMM_LAT - 1);

    fc_state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0]    word_q, word_d;
    logic [ADDR_WIDTH-1:0]    n_q, n_d;
    logic [ADDR_WIDTH-1:0]    p_q, p_d;
    logic [WaitW-1:0]         wait_q, wait_d;
    logic [DataW-1:0]         gemm_q, gemm_d;
    logic [DataW-1:0]         data_q, data_d;
    logic [IdxW-1:0]          res_idx_q, res_idx_d;
    logic [PE_OUT_WIDTH-1:0]  res_val_q, res_val_d;

    logic [DataW-1:0]              acc_sum;
    logic [PE_OUT_WIDTH-1:0]       lane_sum;
    logic [LANES*ADDR_WIDTH-1:0]   wgt_addr_calc;
    logic                          amax_cmp;
    logic [IdxW-1:0]               amax_idx;
    logic [PE_OUT_WIDTH-1:0]       amax_val;

    // Per-lane wrapping add of the stored partial sum and the captured GEMM result.
    always_comb begin
        acc_sum  = '0;
        lane_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            lane_sum = acc_rdata[k*PE_OUT_WIDTH +: PE_OUT_WIDTH]
                     + gemm_q[k*PE_OUT_WIDTH +: PE_OUT_WIDTH];
`ifdef FC_LAYER_CTRL_RELU_EN
            if ((n_q == LastN) && lane_sum[PE_OUT_WIDTH-1]) begin
                lane_sum = '0;
            end
`endif
            acc_sum[k*PE_OUT_WIDTH +: PE_OUT_WIDTH] = lane_sum;
        end
    end

    always_comb begin
        wgt_addr_calc = '0;
        for (int k = 0; k < LANES; k++) begin
            wgt_addr_calc[k*ADDR_WIDTH +: ADDR_WIDTH] =
                ADDR_WIDTH'((32'(p_q) * LANES + 32'(k)) * IN_WORDS + 32'(n_q));
        end
    end

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        n_d       = n_q;
        p_d       = p_q;
        wait_d    = wait_q;
        gemm_d    = gemm_q;
        data_d    = data_q;
        res_idx_d = res_idx_q;
        res_val_d = res_val_q;
        busy      = (state_q != StIdle);
        done      = 1'b0;
        inp_en    = 1'b0;
        inp_addr  = '0;
        wgt_en    = 1'b0;
        wgt_addr  = '0;
        acc_en    = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = '0;
        acc_wdata = '0;
        amax_cmp  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    word_d  = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                acc_en   = 1'b1;
                acc_we   = 1'b1;
                acc_addr = word_q;
                if (word_q == LastWord) begin
                    n_d     = '0;
                    p_d     = '0;
                    state_d = StIssue;
                end else begin
                    word_d = word_q + ADDR_WIDTH'(1);
                end
            end
            StIssue: begin
                inp_en   = 1'b1;
                inp_addr = n_q;
                wgt_en   = 1'b1;
                wgt_addr = wgt_addr_calc;
                wait_d   = '0;
                state_d  = StWaitGemm;
            end
            StWaitGemm: begin
                if (wait_q == LastWait) begin
                    gemm_d  = gemm_result;
                    state_d = StAccRd;
                end else begin
                    wait_d = wait_q + WaitW'(1);
                end
            end
            StAccRd: begin
                acc_en   = 1'b1;
                acc_addr = p_q;
                state_d  = StAccWait;
            end
            StAccWait: begin
                data_d  = acc_sum;
                state_d = StAccWr;
            end
            StAccWr: begin
                acc_en    = 1'b1;
                acc_we    = 1'b1;
                acc_addr  = p_q;
                acc_wdata = data_q;
                if (n_q != LastN) begin
                    n_d     = n_q + ADDR_WIDTH'(1);
                    state_d = StIssue;
                end else if (p_q != LastWord) begin
                    n_d     = '0;
                    p_d     = p_q + ADDR_WIDTH'(1);
                    state_d = StIssue;
                end else begin
                    word_d  = '0;
                    state_d = StMaxRd;
                end
            end
            StMaxRd: begin
                acc_en   = 1'b1;
                acc_addr = word_q;
                state_d  = StMaxWait;
            end
            StMaxWait: begin
                data_d  = acc_rdata;
                state_d = StMaxCmp;
            end
            StMaxCmp: begin
                amax_cmp = 1'b1;
                if (word_q == LastWord) begin
                    // Result lands on entry to FINISH so it is valid alongside done.
                    res_idx_d = amax_idx;
                    res_val_d = amax_val;
                    state_d   = StFinish;
                end else begin
                    word_d  = word_q + ADDR_WIDTH'(1);
                    state_d = StMaxRd;
                end
            end
            StFinish: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            word_q    <= '0;
            n_q       <= '0;
            p_q       <= '0;
            wait_q    <= '0;
            gemm_q    <= '0;
            data_q    <= '0;
            res_idx_q <= '0;
            res_val_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            n_q       <= n_d;
            p_q       <= p_d;
            wait_q    <= wait_d;
            gemm_q    <= gemm_d;
            data_q    <= data_d;
            res_idx_q <= res_idx_d;
            res_val_q <= res_val_d;
        end
    end

    assign result_idx = res_idx_q;
    assign result_val = res_val_q;

    fc_argmax #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .PE_OUT_WIDTH (PE_OUT_WIDTH),
        .LANES        (LANES),
        .OUT_CH       (OUT_CH)
    ) u_argmax (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmp_i     (amax_cmp),
        .first_i   (word_q == '0),
        .word_i    (word_q),
        .data_i    (data_q),
        .nxt_idx_o (amax_idx),
        .nxt_val_o (amax_val)
    );

endmodule

// File: tb/tb_fc_layer_ctrl.sv
// Bench for fc_layer_ctrl: memory/GEMM environment models plus a per-channel dot-product
// reference; honours FC_LAYER_CTRL_RELU_EN when the build defines it.
module tb_fc_layer_ctrl;
    import fc_pkg::*;

    localparam int unsigned AW    = 10;
    localparam int unsigned PW    = 24;
    localparam int unsigned LN    = 2;
    localparam int unsigned IW    = 6;
    localparam int unsigned OC    = 10;
    localparam int unsigned GL    = 18;
    localparam int unsigned NW    = OC / LN;
    localparam int unsigned GW    = LN * PW;
    localparam int unsigned IDXW  = $clog2(OC);
    localparam int unsigned BYTES = 16;
    localparam int unsigned RUN_CYC = NW * IW * (GL + 4) + NW * 4 + 2;

    typedef logic [GW-1:0] gw_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              busy, done;
    logic [IDXW-1:0]   result_idx;
    logic [PW-1:0]     result_val;
    logic              inp_en, wgt_en, acc_en, acc_we;
    logic [AW-1:0]     inp_addr, acc_addr;
    logic [LN*AW-1:0]  wgt_addr;
    logic [GW-1:0]     gemm_result, acc_wdata, acc_rdata;

    int checks = 0;
    int failures = 0;

    logic signed [7:0] inp_mem [IW][BYTES];
    logic signed [7:0] wgt_mem [OC*IW][BYTES];
    gw_t               acc_mem [NW];
    logic signed [PW-1:0] exp_ch [OC];
    int                exp_idx;

    int  ncyc = 0;
    bit  g_pend = 1'b0;
    int  g_cyc = 0;
    gw_t g_val;
    bit  a_pend = 1'b0;
    gw_t a_val;
    int  done_cnt = 0;
    int  issue_cnt = 0;
    int  bad_cnt = 0;

    fc_layer_ctrl #(
        .ADDR_WIDTH   (AW),
        .PE_OUT_WIDTH (PW),
        .LANES        (LN),
        .IN_WORDS     (IW),
        .OUT_CH       (OC),
        .GEMM_LAT     (GL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .result_idx  (result_idx),
        .result_val  (result_val),
        .inp_en      (inp_en),
        .inp_addr    (inp_addr),
        .wgt_en      (wgt_en),
        .wgt_addr    (wgt_addr),
        .gemm_result (gemm_result),
        .acc_en      (acc_en),
        .acc_we      (acc_we),
        .acc_addr    (acc_addr),
        .acc_wdata   (acc_wdata),
        .acc_rdata   (acc_rdata)
    );

    always #5 clk = ~clk;

    // Environment: GEMM returns its dot products exactly GL cycles after the issue cycle and
    // noise otherwise; the accumulator RAM returns read data one cycle after the request.
    always @(negedge clk) begin
        int s;
        int wa;
        ncyc++;
        gemm_result = (g_pend && ncyc == g_cyc + GL) ? g_val : gw_t'({$urandom(), $urandom()});
        acc_rdata   = a_pend ? a_val : gw_t'({$urandom(), $urandom()});
        a_pend      = 1'b0;
        if (!rst_n) begin
            g_pend = 1'b0;
        end else begin
            if (done) done_cnt++;
            if ((inp_en != wgt_en) || (acc_we && !acc_en)) bad_cnt++;
            if (inp_en) begin
                issue_cnt++;
                g_pend = 1'b1;
                g_cyc  = ncyc;
                for (int k = 0; k < LN; k++) begin
                    wa = int'(wgt_addr[k*AW +: AW]);
                    s  = 0;
                    for (int j = 0; j < BYTES; j++) begin
                        if (int'(inp_addr) < IW && wa < OC * IW)
                            s += int'(inp_mem[inp_addr][j]) * int'(wgt_mem[wa][j]);
                    end
                    g_val[k*PW +: PW] = PW'(s);
                end
            end
            if (acc_en && int'(acc_addr) < NW) begin
                if (acc_we) begin
                    acc_mem[acc_addr] = acc_wdata;
                end else begin
                    a_pend = 1'b1;
                    a_val  = acc_mem[acc_addr];
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_all(input int iv, input int wv);
        for (int n = 0; n < IW; n++)
            for (int j = 0; j < BYTES; j++) inp_mem[n][j] = 8'(iv);
        for (int a = 0; a < OC * IW; a++)
            for (int j = 0; j < BYTES; j++) wgt_mem[a][j] = 8'(wv);
    endtask

    task automatic set_channel(input int c, input int wv);
        for (int n = 0; n < IW; n++)
            for (int j = 0; j < BYTES; j++) wgt_mem[c*IW+n][j] = 8'(wv);
    endtask

    task automatic rand_fill();
        for (int n = 0; n < IW; n++)
            for (int j = 0; j < BYTES; j++) inp_mem[n][j] = 8'($urandom_range(0, 255));
        for (int a = 0; a < OC * IW; a++)
            for (int j = 0; j < BYTES; j++) wgt_mem[a][j] = 8'($urandom_range(0, 255));
    endtask

    // Reference: channel c = sum over words n and bytes j of input[n][j] * weight row c*IW+n.
    task automatic compute_expected();
        int s;
        for (int c = 0; c < OC; c++) begin
            s = 0;
            for (int n = 0; n < IW; n++)
                for (int j = 0; j < BYTES; j++)
                    s += int'(inp_mem[n][j]) * int'(wgt_mem[c*IW+n][j]);
            exp_ch[c] = PW'(s);
`ifdef FC_LAYER_CTRL_RELU_EN
            if (exp_ch[c] < 0) exp_ch[c] = '0;
`endif
        end
        exp_idx = 0;
        for (int c = 1; c < OC; c++)
            if (exp_ch[c] > exp_ch[exp_idx]) exp_idx = c;
    endtask

    task automatic run_case(input string tag, input bit spam);
        int  d0, i0, cyc;
        bit  seen;
        gw_t ew;
        logic [IDXW-1:0] held_idx;
        logic [PW-1:0]   held_val;
        compute_expected();
        @(posedge clk); #2;
        d0 = done_cnt;
        i0 = issue_cnt;
        start = 1'b1;
        cyc = 1;
        seen = 1'b0;
        for (int i = 0; i < int'(RUN_CYC) + 200; i++) begin
            @(posedge clk); #2;
            start = spam && (i % 37 == 5);
            cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        check({tag, "_cycles"}, cyc, RUN_CYC);
        check({tag, "_idx"}, result_idx, exp_idx);
        check({tag, "_val"}, signed'(result_val), exp_ch[exp_idx]);
        held_idx = result_idx;
        held_val = result_val;
        repeat (4) @(posedge clk);
        #2;
        check({tag, "_idle_after"}, busy, 0);
        check({tag, "_one_done"}, done_cnt - d0, 1);
        check({tag, "_issues"}, issue_cnt - i0, NW * IW);
        check({tag, "_idx_held"}, result_idx, exp_idx);
        check({tag, "_val_held"}, signed'(result_val), exp_ch[exp_idx]);
        for (int w = 0; w < NW; w++) begin
            ew = '0;
            for (int k = 0; k < LN; k++) ew[k*PW +: PW] = exp_ch[w*LN+k];
            check($sformatf("%s_acc%0d", tag, w), acc_mem[w], ew);
        end
        if (held_idx !== result_idx || held_val !== result_val) bad_cnt++;
    endtask

    initial begin
        int  d0;
        bit  found;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", result_idx, 0);
        check("rst_val", result_val, 0);
        check("rst_en", {inp_en, wgt_en, acc_en, acc_we}, 0);
        rst_n = 1'b1;

        set_all(1, 1);
        run_case("ones", 1'b0);
        check("ones_spec_idx", result_idx, 0);
        check("ones_spec_val", signed'(result_val), 96);

        set_all(1, 1);
        set_channel(7, 2);
        run_case("ch7", 1'b0);
        check("ch7_spec_idx", result_idx, 7);
        check("ch7_spec_val", signed'(result_val), 192);

        set_all(1, 1);
        set_channel(3, 2);
        set_channel(8, 2);
        run_case("tie", 1'b0);
        check("tie_spec_idx", result_idx, 3);

        set_all(1, -1);
        set_channel(5, 0);
        wgt_mem[5*IW][0] = -8'sd1;
        run_case("neg", 1'b0);
`ifdef FC_LAYER_CTRL_RELU_EN
        check("neg_spec_idx", result_idx, 0);
        check("neg_spec_val", signed'(result_val), 0);
`else
        check("neg_spec_idx", result_idx, 5);
        check("neg_spec_val", signed'(result_val), -1);
`endif

        for (int r = 0; r < 3; r++) begin
            rand_fill();
            run_case($sformatf("rand%0d", r), 1'b0);
        end

        // Abort during WAIT_GEMM of pass 2, after a run that left a nonzero result.
        set_all(1, 1);
        set_channel(7, 2);
        run_case("pre_abort", 1'b0);
        rand_fill();
        @(posedge clk); #2;
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (inp_en && wgt_addr[AW-1:0] == AW'(LN * IW)) begin
                found = 1'b1;
                break;
            end
            @(posedge clk); #2;
        end
        check("abort_reached_pass2", found, 1);
        repeat (5) @(posedge clk);
        #2;
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_idx", result_idx, 0);
        check("abort_val", result_val, 0);
        check("abort_en", {done, inp_en, wgt_en, acc_en, acc_we}, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (RUN_CYC) @(posedge clk);
        #2;
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_stays_idle", busy, 0);
        rand_fill();
        run_case("after_abort", 1'b0);

        rand_fill();
        run_case("spam", 1'b1);

        check("enable_rules", bad_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fc_layer_ctrl.md
FC_LAYER_CTRL -- requirements
Module: fc_layer_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, memory address width.
REQ-002 Parameter PE_OUT_WIDTH, default 24, signed accumulator width.
REQ-003 Parameter LANES, default 2, output channels computed per pass (>=1).
REQ-004 Parameter IN_WORDS, default 6, input memory words per output channel (>=1).
REQ-005 Parameter OUT_CH, default 10, total output channels; a multiple of LANES.
REQ-006 Parameter GEMM_LAT, default 18, cycles from issuing an input/weight address to a valid gemm_result.
REQ-007 Clock and reset: one clock; reset is asynchronous and active-low; ports clk and rst_n.
REQ-008 clk  in  1  rising-edge clock.
REQ-009 rst_n  in  1  asynchronous active-low reset.
REQ-010 start  in  1  one-cycle pulse; ignored unless busy=0.
REQ-011 busy  out  1  high from the cycle after an accepted start until done.
REQ-012 done  out  1  one-cycle pulse when the result is valid.
REQ-013 result_idx  out  $clog2(OUT_CH)  argmax channel; held until the next done.
REQ-014 result_val  out  PE_OUT_WIDTH  maximum value; held until the next done.
REQ-015 inp_en/inp_addr  out  1/ADDR_WIDTH  input memory read port.
REQ-016 wgt_en/wgt_addr  out  1/LANES*ADDR_WIDTH  weight read ports; lane k occupies slice k.
REQ-017 gemm_result  in  LANES*PE_OUT_WIDTH  signed partial sums, lane k occupies slice k.
REQ-018 acc_en/acc_we/acc_addr  out  1/1/ADDR_WIDTH  accumulator memory port; word a holds channels a*LANES..a*LANES+LANES-1.
REQ-019 acc_wdata/acc_rdata  out/in  LANES*PE_OUT_WIDTH  accumulator write and read data; read latency is 1 cycle.

Function
REQ-020 States: IDLE, CLEAR, ISSUE, WAIT_GEMM, ACC_RD, ACC_WAIT, ACC_WR, MAX_RD, MAX_WAIT, MAX_CMP, FINISH.
REQ-021 IDLE plus start goes to CLEAR, which writes zero to acc words 0..OUT_CH/LANES-1 at one word per cycle, then goes to ISSUE with counters n=0 and p=0.
REQ-022 ISSUE asserts inp_en and wgt_en for 1 cycle, with inp_addr=n and lane-k wgt_addr=(p*LANES+k)*IN_WORDS+n, then goes to WAIT_GEMM.
REQ-023 WAIT_GEMM counts GEMM_LAT-1 cycles, then samples gemm_result into a register and goes to ACC_RD.
REQ-024 ACC_RD reads acc word p; ACC_WAIT waits 1 cycle; ACC_WR writes, per lane, acc_rdata+gemm_result with a PE_OUT_WIDTH-bit wrapping add and no saturation.
REQ-025 After ACC_WR: if n<IN_WORDS-1, increment n and go to ISSUE; else if p<OUT_CH/LANES-1, set n=0, increment p and go to ISSUE; else go to MAX_RD.
REQ-026 MAX_RD/MAX_WAIT/MAX_CMP read each acc word in turn and compare each lane signed against the running max, in ascending channel order.
REQ-027 Channel 0 seeds the running max; on a tie the lower index is kept.
REQ-028 FINISH registers result_idx and result_val, pulses done, and returns to IDLE.
REQ-029 Enables are high only in the states that use them; acc_we is high only in CLEAR and ACC_WR.
REQ-030 start while busy=1 has no effect; a run takes exactly (OUT_CH/LANES)*IN_WORDS*(GEMM_LAT+4)+OUT_CH/LANES*4+2 cycles, with the exact constant matching the implementation and documented in the package.

Reset
REQ-031 On rst_n low, state goes to IDLE, all counters go to 0, and every output including result_idx and result_val goes to 0, with no dependence on the clock.
REQ-032 Reset asserted mid-run aborts the run; done does not pulse and the acc contents are undefined.

Configuration
REQ-033 Macro FC_LAYER_CTRL_RELU_EN: when defined, ACC_WR on the final input word (n=IN_WORDS-1) writes max(sum,0) per lane; when undefined, it writes the raw sum.

Structure
REQ-034 Package fc_pkg holds the state enumeration, default parameter constants and the cycle-count formula.
REQ-035 One sub-module, fc_argmax, holds the running-max compare and index tracking.

Verification
REQ-036 Defaults, weights all 1, inputs all 1 (16 lanes of 8-bit data per word) -> every channel sums to 96, result_idx=0, result_val=96 (RELU off).
REQ-037 Only channel 7 weights = 2 -> result_idx=7, result_val=192.
REQ-038 Channels 3 and 8 tie at the maximum -> result_idx=3.
REQ-039 All sums negative, channel 5 = -1 the largest -> RELU off: idx=5, val=-1; RELU on: idx=0, val=0.
REQ-040 rst_n pulsed low during WAIT_GEMM of pass 2, then start -> no done for the aborted run, and the second run gives the correct result.
REQ-041 start pulsed while busy -> no restart, and exactly one done pulse per accepted start.
